// File: rtl/graph_plot_sched_pkg.sv
// Shared types and defaults for the graph point path: sequencer states,
// screen geometry and the signed coordinate type produced by `graph`.
package graph_pkg;

    localparam int DEF_N_POINTS = 64;
    localparam int DEF_COORD_W  = 32;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef logic signed [DEF_COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        GRST,
        WAIT,
        EMIT,
        FIN
    } state_t;

endpackage

// File: rtl/graph_plot_sched_if.sv
// Point stream from the sequencer to the pixel plotter (valid/ready).
interface graph_plot_sched_if #(
    parameter int OUT_XW = 10,
    parameter int OUT_YW = 9
);

    logic              pt_valid;
    logic              pt_ready;
    logic [OUT_XW-1:0] pt_x;
    logic [OUT_YW-1:0] pt_y;
    logic              pt_last;

    modport master (output pt_valid, pt_x, pt_y, pt_last, input pt_ready);
    modport slave  (input pt_valid, pt_x, pt_y, pt_last, output pt_ready);

endinterface

// File: rtl/graph_plot_sched_clip.sv
// Combinational on-screen test for one signed point, plus the coordinates
// truncated to screen width.
module graph_clip
    import graph_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int OUT_XW   = 10,
    parameter int OUT_YW   = 9
) (
    input  logic signed [COORD_W-1:0] x,
    input  logic signed [COORD_W-1:0] y,
    output logic                      in_range,
    output logic        [OUT_XW-1:0]  x_trunc,
    output logic        [OUT_YW-1:0]  y_trunc
);

    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

    // Sign bit stands in for ">= 0" so the whole test stays signed.
    assign in_range = !x[COORD_W-1] && (x < X_LIM) &&
                      !y[COORD_W-1] && (y < Y_LIM);
    assign x_trunc  = x[OUT_XW-1:0];
    assign y_trunc  = y[OUT_YW-1:0];

endmodule

// File: rtl/graph_plot_sched.sv
// Restarts `graph`, waits for its complete flag, then streams the on-screen
// points of xs/ys in index order to the plotter.
module graph_plot_sched
    import graph_pkg::*;
#(
    parameter int N_POINTS   = DEF_N_POINTS,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int OUT_XW     = 10,
    parameter int OUT_YW     = 9,
    parameter int RST_CYCLES = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      graph_rst,
    input  logic                      graph_complete,
    input  logic signed [COORD_W-1:0] xs [N_POINTS],
    input  logic signed [COORD_W-1:0] ys [N_POINTS],
    graph_plot_sched_if.master        pt,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [6:0]                clipped_cnt
);

    localparam int IDX_W = $clog2(N_POINTS);
    localparam int CNT_W = $clog2((TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
    localparam logic [6:0]       CLIP_MAX = 7'(N_POINTS);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic               valid_nx, last_nx, err_nx, advance;
    logic [OUT_XW-1:0]  x_nx, clip_x;
    logic [OUT_YW-1:0]  y_nx, clip_y;
    logic [6:0]         clip_nx;
    logic               in_range;

    graph_clip #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .OUT_XW   (OUT_XW),
        .OUT_YW   (OUT_YW)
    ) u_clip (
        .x        (xs[idx]),
        .y        (ys[idx]),
        .in_range (in_range),
        .x_trunc  (clip_x),
        .y_trunc  (clip_y)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case, so no branch can leave one unassigned and infer a latch.
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        valid_nx = pt.pt_valid;
        x_nx     = pt.pt_x;
        y_nx     = pt.pt_y;
        last_nx  = pt.pt_last;
        err_nx   = err;
        clip_nx  = clipped_cnt;
        advance  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    clip_nx  = '0;
                    err_nx   = 1'b0;
                    state_nx = GRST;
                end
            end
            GRST: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (graph_complete) begin
                    idx_nx   = '0;
                    state_nx = EMIT;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = FIN;
                end
            end
            EMIT: begin
                // Losing complete means xs/ys may already be changing; abandon the run.
                if (!graph_complete) begin
                    err_nx   = 1'b1;
                    valid_nx = 1'b0;
                    state_nx = FIN;
                end else if (!pt.pt_valid) begin
                    if (in_range) begin
                        valid_nx = 1'b1;
                        x_nx     = clip_x;
                        y_nx     = clip_y;
                        last_nx  = (idx == LAST_IDX);
                    end else begin
                        clip_nx  = (clipped_cnt == CLIP_MAX) ? clipped_cnt : clipped_cnt + 7'd1;
                        advance  = 1'b1;
                    end
                end else if (pt.pt_ready) begin
                    valid_nx = 1'b0;
                    advance  = 1'b1;
                end
            end
            FIN: begin
                idx_nx   = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (advance) begin
            if (idx == LAST_IDX) state_nx = FIN;
            else                 idx_nx   = idx + 1'b1;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            pt.pt_valid <= 1'b0;
            pt.pt_x     <= '0;
            pt.pt_y     <= '0;
            pt.pt_last  <= 1'b0;
            err         <= 1'b0;
            clipped_cnt <= '0;
            graph_rst   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            pt.pt_valid <= valid_nx;
            pt.pt_x     <= x_nx;
            pt.pt_y     <= y_nx;
            pt.pt_last  <= last_nx;
            err         <= err_nx;
            clipped_cnt <= clip_nx;
            graph_rst   <= (state_nx == GRST);
            busy        <= (state_nx != IDLE);
            done        <= (state_nx == FIN);
        end
    end

endmodule

// File: tb/tb_graph_plot_sched.sv
// Scoreboard bench for graph_plot_sched: directed runs push expected points,
// a negedge monitor pops and compares them on every handshake.
module tb_graph_plot_sched;
    import graph_pkg::*;

    localparam int NP = 64;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       last;
    } pt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       graph_complete = 1'b0;
    logic       graph_rst, busy, done, err;
    logic [6:0] clipped_cnt;
    coord_t     xs [NP];
    coord_t     ys [NP];

    graph_plot_sched_if #(.OUT_XW(10), .OUT_YW(9)) pt ();

    graph_plot_sched #(.TIMEOUT(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .graph_rst      (graph_rst),
        .graph_complete (graph_complete),
        .xs             (xs),
        .ys             (ys),
        .pt             (pt),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .clipped_cnt    (clipped_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   last_cnt = 0;
    int   last_hs_cyc = 0;
    int   ready_mode = 0;
    int   hs0 = 0;
    int   last0 = 0;
    pt_t  exp_q [$];
    logic hold_prev = 1'b0;
    pt_t  prev_pt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nominal();
        for (int i = 0; i < NP; i++) begin
            xs[i] = coord_t'(10 * i);
            ys[i] = coord_t'(5 * i);
        end
    endtask

    task automatic build_expected();
        pt_t e;
        exp_q.delete();
        for (int i = 0; i < NP; i++) begin
            if (xs[i] >= 0 && xs[i] < 640 && ys[i] >= 0 && ys[i] < 480) begin
                e.x    = xs[i][9:0];
                e.y    = ys[i][8:0];
                e.last = (i == NP - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: samples mid-cycle, one pop per handshake.
    always @(negedge clk) begin
        pt_t cur;
        cur = {pt.pt_x, pt.pt_y, pt.pt_last};
        if (pt.pt_valid && hold_prev) check("hold_stable", cur, prev_pt);
        if (pt.pt_valid && pt.pt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_point actual=%0h required=none (cycle %0d)", cur, cyc);
            end else begin
                check("point", cur, exp_q.pop_front());
            end
            hs_count++;
            if (pt.pt_last) last_cnt++;
            last_hs_cyc = cyc;
        end
        hold_prev = pt.pt_valid && !pt.pt_ready;
        prev_pt   = cur;
    end

    initial begin
        pt.pt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pt.pt_ready = 1'b1;
                1:       pt.pt_ready = ($urandom_range(0, 9) < 3);
                default: pt.pt_ready = 1'b0;
            endcase
        end
    end

    task automatic start_run(input string tag);
        int n;
        int hi;
        build_expected();
        hs0   = hs_count;
        last0 = last_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_grst_rise"}, graph_rst, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_err_cleared"}, err, 0);
        hi = 1;
        n  = 0;
        while (graph_rst && n < 20) begin
            step();
            n++;
            if (graph_rst) hi++;
        end
        check({tag, "_grst_len"}, hi, 3);
        repeat (20) step();
        graph_complete = 1'b1;
    endtask

    task automatic finish_run(input string tag, input int exp_pts, input int exp_clip,
                              input int exp_last, input int exp_lat);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_clipped_cnt"}, clipped_cnt, exp_clip);
        check({tag, "_points"}, hs_count - hs0, exp_pts);
        check({tag, "_last_count"}, last_cnt - last0, exp_last);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_done_latency"}, cyc - last_hs_cyc, exp_lat);
        graph_complete = 1'b0;
        ready_mode     = 0;
        step();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_points(input string tag, input int cnt);
        int n;
        n = 0;
        while (hs_count - hs0 < cnt && n < 1000) begin
            step();
            n++;
        end
        check({tag, "_reach"}, hs_count - hs0, cnt);
    endtask

    task automatic run_timeout();
        logic saw;
        fill_nominal();
        graph_complete = 1'b0;
        saw   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 105; n++) begin
            if (pt.pt_valid) saw = 1'b1;
            if (n == 3)   check("to_grst_t3", graph_rst, 1);
            if (n == 4)   check("to_grst_t4", graph_rst, 0);
            if (n == 103) check("to_early", {done, err}, 2'b00);
            if (n == 104) check("to_fire", {done, err, busy}, 3'b111);
            if (n == 105) check("to_after", {done, err, busy}, 3'b010);
            if (n < 105) step();
        end
        check("to_no_valid", saw, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_nominal();
        #1;
        // Reset with start held: nothing may move.
        rst = 1'b1;
        repeat (2) step();
        start = 1'b1;
        step();
        check("reset_outputs",
              {graph_rst, busy, done, err, clipped_cnt, pt.pt_valid, pt.pt_x, pt.pt_y, pt.pt_last}, 0);
        start = 1'b0;
        rst   = 1'b0;
        step();
        check("reset_start_ignored", {busy, graph_rst}, 2'b00);

        // Nominal: 64 points (0,0)..(630,315), last on the 64th.
        fill_nominal();
        ready_mode = 0;
        start_run("nom");
        finish_run("nom", 64, 0, 1, 1);

        // Clipping: indices 5, 10, 20, 63 dropped; idx 63 costs one extra cycle.
        fill_nominal();
        xs[5]  = -1;
        xs[10] = 640;
        ys[20] = 480;
        xs[63] = 700;
        start_run("clip");
        finish_run("clip", 60, 4, 0, 2);

        // Backpressure with a mid-run start that must be ignored.
        fill_nominal();
        ready_mode = 1;
        start_run("bp");
        wait_points("bp", 5);
        start = 1'b1;
        step();
        start = 1'b0;
        check("bp_no_restart", graph_rst, 0);
        finish_run("bp", 64, 0, 1, 1);

        run_timeout();

        // complete dropped while point 10 is held.
        fill_nominal();
        ready_mode = 0;
        start_run("drop");
        wait_points("drop", 10);
        ready_mode = 2;
        step();
        check("drop_held", pt.pt_valid, 1);
        graph_complete = 1'b0;
        step();
        check("drop_abort", {pt.pt_valid, err, done}, 3'b011);
        check("drop_points", hs_count - hs0, 10);
        step();
        check("drop_idle", {done, busy, err}, 3'b001);
        exp_q.delete();
        ready_mode = 0;

        // Reset mid-EMIT, then a clean nominal run.
        fill_nominal();
        start_run("rstab");
        wait_points("rstab", 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstab_outputs",
              {graph_rst, busy, done, err, clipped_cnt, pt.pt_valid, pt.pt_x, pt.pt_y, pt.pt_last}, 0);
        graph_complete = 1'b0;
        exp_q.delete();
        step();
        check("rstab_idle", busy, 0);

        start_run("renom");
        finish_run("renom", 64, 0, 1, 1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
